// File: rtl/tile_addr_gen.sv
// Tile-map pixel address generator: writable tile map, clear FSM, and a
// pixel pipeline that turns (h_cnt, v_cnt) into an atlas ROM address.
// Latency: pixel_addr/valid 2 cycles after h_cnt/v_cnt; rd_tile 1 cycle.
// No backpressure. Writes are accepted only while wr_ready is high.
module tile_addr_gen #(
  parameter int MAP_W       = 20,
  parameter int MAP_H       = 10,
  parameter int TILE_SHIFT  = 4,
  parameter int SCALE_SHIFT = 1,
  parameter int TILE_BITS   = 3,
  parameter int ATLAS_COLS  = 2,
  parameter int FILL_TILE   = 2,
  parameter int ADDR_W      = 17,
  localparam int X_W        = $clog2(MAP_W),
  localparam int Y_W        = $clog2(MAP_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [9:0]           h_cnt,
  input  logic [9:0]           v_cnt,
  input  logic                 wr_en,
  input  logic [X_W-1:0]       wr_x,
  input  logic [Y_W-1:0]       wr_y,
  input  logic [TILE_BITS-1:0] wr_tile,
  output logic                 wr_ready,
  input  logic [X_W-1:0]       rd_x,
  input  logic [Y_W-1:0]       rd_y,
  output logic [TILE_BITS-1:0] rd_tile,
  output logic                 busy,
  output logic [ADDR_W-1:0]    pixel_addr,
  output logic                 valid
);

  localparam int CELLS = MAP_W * MAP_H;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [X_W:0] LIM_X = (X_W+1)'(MAP_W);
  localparam logic [Y_W:0] LIM_Y = (Y_W+1)'(MAP_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_clr_idx;
  logic [IDX_W-1:0]     w_clr_idx_nxt;

  // Tile map storage; contents survive reset and are set by the clear FSM.
  logic [TILE_BITS-1:0] r_map [CELLS];

  logic                 w_user_we;
  logic [IDX_W-1:0]     w_wr_idx;
  logic                 w_mem_we;
  logic [IDX_W-1:0]     w_mem_idx;
  logic [TILE_BITS-1:0] w_mem_dat;

  logic                 w_rd_ok;
  logic [IDX_W-1:0]     w_rd_idx;
  logic [TILE_BITS-1:0] r_rd_tile;

  logic [9:0]           w_hc;
  logic [9:0]           w_vc;
  logic [9:0]           w_tx_raw;
  logic [9:0]           w_ty_raw;
  logic [X_W-1:0]       w_tx;
  logic [Y_W-1:0]       w_ty;
  logic [IDX_W-1:0]     w_disp_idx;
  logic                 w_in_map;

  logic [TILE_BITS-1:0] r_s1_tile;
  logic [TILE_SHIFT-1:0] r_s1_hl;
  logic [TILE_SHIFT-1:0] r_s1_vl;
  logic                 r_s1_in_map;
  logic [ADDR_W-1:0]    w_addr;

  logic [ADDR_W-1:0]    r_pixel_addr;
  logic                 r_valid;

  // FSM state and clear-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // Next state: start always (re)starts a clear from cell 0; the clear
  // walks every cell once and then hands over to display.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_CLEAR;
          w_clr_idx_nxt = '0;
        end
      end
      S_CLEAR: begin
        if (start) begin
          w_clr_idx_nxt = '0;
        end else if (r_clr_idx == IDX_W'(CELLS - 1)) begin
          w_state_nxt   = S_RUN;
          w_clr_idx_nxt = '0;
        end else begin
          w_clr_idx_nxt = r_clr_idx + IDX_W'(1);
        end
      end
      S_RUN: begin
        if (start) begin
          w_state_nxt   = S_CLEAR;
          w_clr_idx_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_clr_idx_nxt = '0;
      end
    endcase
  end

  assign busy     = (r_state == S_CLEAR);
  assign wr_ready = (r_state == S_RUN);

  assign w_user_we = wr_en && wr_ready && ({1'b0, wr_x} < LIM_X) && ({1'b0, wr_y} < LIM_Y);
  assign w_wr_idx  = IDX_W'(wr_y) * IDX_W'(MAP_W) + IDX_W'(wr_x);

  // Single write port: the clear FSM owns it during CLEAR, game logic in RUN.
  always_comb begin
    w_mem_we  = 1'b0;
    w_mem_idx = w_wr_idx;
    w_mem_dat = wr_tile;
    if (r_state == S_CLEAR) begin
      w_mem_we  = 1'b1;
      w_mem_idx = r_clr_idx;
      w_mem_dat = TILE_BITS'(FILL_TILE);
    end else if (w_user_we) begin
      w_mem_we  = 1'b1;
    end
  end

  // Map write; reads elsewhere sample the pre-write value in the same cycle.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_map[w_mem_idx] <= w_mem_dat;
    end
  end

  assign w_rd_ok  = ({1'b0, rd_x} < LIM_X) && ({1'b0, rd_y} < LIM_Y);
  assign w_rd_idx = IDX_W'(rd_y) * IDX_W'(MAP_W) + IDX_W'(rd_x);

  // Registered read-back; out-of-map coordinates read as 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_tile <= '0;
    end else begin
      r_rd_tile <= w_rd_ok ? r_map[w_rd_idx] : '0;
    end
  end

  assign rd_tile = r_rd_tile;

  // S0: downscale to map pixels, find the tile cell (clamped so the RAM
  // address stays legal even off-map), and decide if the pixel is on the map.
  assign w_hc       = h_cnt >> SCALE_SHIFT;
  assign w_vc       = v_cnt >> SCALE_SHIFT;
  assign w_tx_raw   = w_hc >> TILE_SHIFT;
  assign w_ty_raw   = w_vc >> TILE_SHIFT;
  assign w_tx       = (w_tx_raw > 10'(MAP_W - 1)) ? X_W'(MAP_W - 1) : w_tx_raw[X_W-1:0];
  assign w_ty       = (w_ty_raw > 10'(MAP_H - 1)) ? Y_W'(MAP_H - 1) : w_ty_raw[Y_W-1:0];
  assign w_disp_idx = IDX_W'(w_ty) * IDX_W'(MAP_W) + IDX_W'(w_tx);
  assign w_in_map   = (r_state == S_RUN)
                   && (32'(w_hc) < 32'(MAP_W << TILE_SHIFT))
                   && (32'(w_vc) < 32'(MAP_H << TILE_SHIFT));

  // S1: capture tile index from the map plus the in-tile pixel offsets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_tile   <= '0;
      r_s1_hl     <= '0;
      r_s1_vl     <= '0;
      r_s1_in_map <= 1'b0;
    end else begin
      r_s1_tile   <= r_map[w_disp_idx];
      r_s1_hl     <= w_hc[TILE_SHIFT-1:0];
      r_s1_vl     <= w_vc[TILE_SHIFT-1:0];
      r_s1_in_map <= w_in_map;
    end
  end

  // Atlas is ATLAS_COLS tiles wide; tile t sits at row t/ATLAS_COLS,
  // column t%ATLAS_COLS, and the address is row-major in atlas pixels.
  assign w_addr = ADDR_W'(
      (((32'(r_s1_tile) / 32'(ATLAS_COLS)) << TILE_SHIFT) + 32'(r_s1_vl))
        * 32'(ATLAS_COLS << TILE_SHIFT)
    + ((32'(r_s1_tile) % 32'(ATLAS_COLS)) << TILE_SHIFT)
    + 32'(r_s1_hl));

  // S2: output register; off-map pixels present address 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pixel_addr <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_pixel_addr <= r_s1_in_map ? w_addr : '0;
      r_valid      <= r_s1_in_map;
    end
  end

  assign pixel_addr = r_pixel_addr;
  assign valid      = r_valid;

endmodule

// File: tb/tb_tile_addr_gen.sv
// Bench for tile_addr_gen: directed and random stimulus against a tile-map
// reference model; expected pixel/read-back results are queued with the
// cycle they are due and compared by an independent monitor.
module tb_tile_addr_gen;

  localparam int MAP_W = 20;
  localparam int MAP_H = 10;
  localparam int FILL  = 2;
  localparam int BIG   = 1 << 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        wr_en;
  logic [4:0]  wr_x;
  logic [3:0]  wr_y;
  logic [2:0]  wr_tile;
  logic        wr_ready;
  logic [4:0]  rd_x;
  logic [3:0]  rd_y;
  logic [2:0]  rd_tile;
  logic        busy;
  logic [16:0] pixel_addr;
  logic        valid;

  tile_addr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_tile    (wr_tile),
    .wr_ready   (wr_ready),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_tile    (rd_tile),
    .busy       (busy),
    .pixel_addr (pixel_addr),
    .valid      (valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: map contents and the cycle window of the clear.
  int model_map [MAP_W*MAP_H];
  bit map_known  = 1'b0;
  int clear_from = BIG;
  int run_from   = BIG;
  int busy_cnt   = 0;

  typedef struct { int due; int v; int a; } pexp_t;
  typedef struct { int due; int t; } rexp_t;
  pexp_t pq[$];
  rexp_t rq[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int in_run(input int d);
    return int'(d >= run_from);
  endfunction

  function automatic int in_clear(input int d);
    return int'(d >= clear_from && d < run_from);
  endfunction

  function automatic int ref_valid(input int h, input int v, input int d);
    return int'(in_run(d) != 0 && (h / 2) < MAP_W * 16 && (v / 2) < MAP_H * 16);
  endfunction

  function automatic int ref_addr(input int h, input int v, input int d);
    int hc, vc, tx, ty, t;
    if (ref_valid(h, v, d) == 0) return 0;
    hc = h / 2;
    vc = v / 2;
    tx = hc / 16;
    ty = vc / 16;
    t  = model_map[ty * MAP_W + tx];
    return ((((t / 2) * 16 + vc % 16) * 32) + (t % 2) * 16 + hc % 16) % (1 << 17);
  endfunction

  function automatic int ref_rd(input int x, input int y);
    if (x < MAP_W && y < MAP_H) return model_map[y * MAP_W + x];
    return 0;
  endfunction

  // One cycle of stimulus. xa >= 0 supplies an explicit expected address
  // (with xv as expected valid) instead of the model's answer.
  task automatic step(input int h, input int v, input int rx, input int ry,
                      input int we, input int wx, input int wy, input int wt,
                      input int st, input int xa, input int xv);
    int    d;
    pexp_t pe;
    rexp_t re;
    @(posedge clk);
    #1;
    d = cyc;
    chk("busy", int'(busy), in_clear(d));
    chk("wr_ready", int'(wr_ready), in_run(d));
    if (busy) busy_cnt++;
    h_cnt   = 10'(h);
    v_cnt   = 10'(v);
    rd_x    = 5'(rx);
    rd_y    = 4'(ry);
    wr_en   = (we != 0);
    wr_x    = 5'(wx);
    wr_y    = 4'(wy);
    wr_tile = 3'(wt);
    start   = (st != 0);
    pe.due = d + 2;
    if (xa >= 0) begin
      pe.v = xv;
      pe.a = xa;
    end else begin
      pe.v = ref_valid(h, v, d);
      pe.a = ref_addr(h, v, d);
    end
    pq.push_back(pe);
    if (map_known && in_clear(d) == 0) begin
      re.due = d + 1;
      re.t   = ref_rd(rx, ry);
      rq.push_back(re);
    end
    if (we != 0 && in_run(d) != 0 && wx < MAP_W && wy < MAP_H)
      model_map[wy * MAP_W + wx] = wt;
    if (st != 0) begin
      clear_from = d + 1;
      run_from   = d + 1 + MAP_W * MAP_H;
      foreach (model_map[i]) model_map[i] = FILL;
      map_known = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 639), $urandom_range(0, 479), 31, 15, 0, 0, 0, 0, 0, -1, 0);
  endtask

  // Asynchronous reset between clock edges; outputs must drop at once.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_pixel_addr"}, int'(pixel_addr), 0);
    chk({tag, "_wr_ready"}, int'(wr_ready), 0);
    chk({tag, "_rd_tile"}, int'(rd_tile), 0);
    pq.delete();
    rq.delete();
    map_known  = 1'b0;
    clear_from = BIG;
    run_from   = BIG;
    start      = 1'b0;
    wr_en      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compares every queued expectation on the cycle it is due.
  pexp_t mon_pe;
  rexp_t mon_re;
  always @(negedge clk) begin
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      mon_pe = pq.pop_front();
      chk("valid", int'(valid), mon_pe.v);
      chk("pixel_addr", int'(pixel_addr), mon_pe.a);
    end
    while (rq.size() > 0 && rq[0].due <= cyc) begin
      mon_re = rq.pop_front();
      chk("rd_tile", int'(rd_tile), mon_re.t);
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; h_cnt = '0; v_cnt = '0;
    wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_tile = '0; rd_x = '0; rd_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_pixel_addr", int'(pixel_addr), 0);
    chk("rst_rd_tile", int'(rd_tile), 0);
    @(negedge clk);
    rst = 1'b1;
    idle(3);

    // First clear, with a write attempted late in the clear (must be ignored).
    busy_cnt = 0;
    step(0, 0, 31, 15, 0, 0, 0, 0, 1, -1, 0);
    for (int i = 0; i < 205; i++) begin
      if (i == 150) step(6, 4, 31, 15, 1, 0, 0, 5, 0, -1, 0);
      else          idle(1);
    end
    chk("busy_count", busy_cnt, MAP_W * MAP_H);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);

    // Directed pixel and read-back cases.
    step(6, 4, 0, 0, 0, 0, 0, 0, 0, 579, 1);
    step(0, 0, 31, 15, 1, 0, 0, 3, 0, -1, 0);
    step(0, 0, 31, 15, 1, 1, 0, 1, 0, -1, 0);
    step(6, 4, 0, 0, 0, 0, 0, 0, 0, 595, 1);
    step(38, 4, 1, 0, 0, 0, 0, 0, 0, 83, 1);
    step(639, 318, 19, 9, 0, 0, 0, 0, 0, -1, 0);
    step(0, 320, 20, 0, 0, 0, 0, 0, 0, 0, 0);
    step(639, 479, 0, 10, 1, 20, 0, 7, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, -1, 0);
    // Same-cycle write and read of one cell: read-back sees the old value.
    step(6, 4, 2, 0, 1, 2, 0, 6, 0, -1, 0);
    step(4, 0, 2, 0, 0, 0, 0, 0, 0, -1, 0);
    idle(3);

    // Random traffic with a re-clear issued from RUN part way through.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 639), $urandom_range(0, 479),
           $urandom_range(0, 31), $urandom_range(0, 15),
           int'($urandom_range(0, 3) == 0),
           $urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 7),
           int'(i == 700), -1, 0);
    end

    // Reset while pixels are valid in RUN.
    step(6, 4, 31, 15, 0, 0, 0, 0, 0, -1, 0);
    step(6, 4, 31, 15, 0, 0, 0, 0, 0, -1, 0);
    step(6, 4, 31, 15, 0, 0, 0, 0, 0, -1, 0);
    async_reset("run_reset");

    // Reset 57 cycles into a clear, then a full clear after a new start.
    step(0, 0, 31, 15, 0, 0, 0, 0, 1, -1, 0);
    idle(57);
    async_reset("clear_reset");
    busy_cnt = 0;
    step(0, 0, 31, 15, 0, 0, 0, 0, 1, -1, 0);
    idle(205);
    chk("busy_count_after_reset", busy_cnt, MAP_W * MAP_H);
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 639), $urandom_range(0, 479),
           $urandom_range(0, 31), $urandom_range(0, 15), 0, 0, 0, 0, 0, -1, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("queues_drained", pq.size() + rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
